// File: rtl/b3_serial_incr_pkg.sv
// Shared definitions for the digit-serial base-3 counter: ternary digit
// encodings, FSM states and a digit sanitiser used on loads.
package b3_serial_incr_pkg;

  localparam logic [1:0] B3_ZERO = 2'b00;
  localparam logic [1:0] B3_ONE  = 2'b01;
  localparam logic [1:0] B3_TWO  = 2'b10;
  localparam logic [1:0] B3_ILL  = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // The illegal code 11 is replaced with zero so that the adder never sees it.
  function automatic logic [1:0] b3_sanitize(input logic [1:0] d);
    return (d == B3_ILL) ? B3_ZERO : d;
  endfunction

endpackage

// File: rtl/b3_serial_incr_if.sv
// Command/status bundle of the base-3 serial counter. The master issues
// load/inc commands, and the slave (the counter) reports its contents and status.
interface b3_serial_incr_if #(
  parameter int N = 4
);
  logic           load;
  logic [2*N-1:0] load_val;
  logic           inc;
  logic [2*N-1:0] value;
  logic           busy;
  logic           done;
  logic           ovf;
  logic           err;

  modport master (
    output load, load_val, inc,
    input  value, busy, done, ovf, err
  );

  modport slave (
    input  load, load_val, inc,
    output value, busy, done, ovf, err
  );
endinterface

// File: rtl/b3_serial_incr_halfadder.sv
// Single-digit base-3 half adder: adds a carry-in of 0 or 1 to one ternary digit.
module b3_halfadder
  import b3_serial_incr_pkg::*;
(
  input  logic [1:0] digit,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  // The illegal code falls through to zero. Loads sanitise digits, so that code is never presented here.
  always_comb begin
    sum  = B3_ZERO;
    cout = 1'b0;
    case (digit)
      B3_ZERO: sum = cin ? B3_ONE : B3_ZERO;
      B3_ONE:  sum = cin ? B3_TWO : B3_ONE;
      B3_TWO: begin
        sum  = cin ? B3_ZERO : B3_TWO;
        cout = cin;
      end
      default: sum = B3_ZERO;
    endcase
  end

endmodule

// File: rtl/b3_serial_incr.sv
// N-digit base-3 counter register. Each increment ripples a carry LSB-first,
// one digit per clock, through a single shared half-adder cell.
module b3_serial_incr
  import b3_serial_incr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clock,
  input  logic              reset_,
  b3_serial_incr_if.slave   bus
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST_PTR = PW'(N - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            carry_q, carry_d;
  logic [2*N-1:0]  value_q, value_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  logic [2*N-1:0]  load_clean;
  logic            load_bad;
  logic [1:0]      digit_sel;
  logic [1:0]      ha_sum;
  logic            ha_cout;

  always_comb begin
    load_clean = '0;
    load_bad   = 1'b0;
    for (int i = 0; i < N; i++) begin
      load_clean[2*i +: 2] = b3_sanitize(bus.load_val[2*i +: 2]);
      if (bus.load_val[2*i +: 2] == B3_ILL) load_bad = 1'b1;
    end
  end

  assign digit_sel = value_q[{ptr_q, 1'b0} +: 2];

  b3_halfadder u_halfadder (
    .digit (digit_sel),
    .cin   (carry_q),
    .sum   (ha_sum),
    .cout  (ha_cout)
  );

  // The ripple ends when the carry dies out or the top digit has been processed.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    carry_d = carry_q;
    value_d = value_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          value_d = load_clean;
          err_d   = load_bad;
          ovf_d   = 1'b0;
        end else if (bus.inc) begin
          state_d = S_RUN;
          ptr_d   = '0;
          carry_d = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        value_d[{ptr_q, 1'b0} +: 2] = ha_sum;
        carry_d = ha_cout;
        if (!ha_cout || (ptr_q == LAST_PTR)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          ovf_d   = ha_cout && (ptr_q == LAST_PTR);
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      carry_q <= 1'b0;
      value_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      carry_q <= carry_d;
      value_q <= value_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign bus.value = value_q;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = done_q;
  assign bus.ovf   = ovf_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_b3_serial_incr.sv
// Directed, table-driven bench for the 4-digit base-3 serial counter, with
// hand-written sequences for reset and the worst-case ripple.
module tb_b3_serial_incr;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset_;
  int   checks   = 0;
  int   failures = 0;

  b3_serial_incr_if #(.N(N)) bus ();

  b3_serial_incr #(.N(N)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       load;
    logic       inc;
    logic [7:0] load_val;
    logic [7:0] e_value;
    logic       e_busy;
    logic       e_done;
    logic       e_ovf;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string name, input logic rst_n, input logic load, input logic inc,
                        input logic [7:0] load_val, input logic [7:0] e_value,
                        input logic e_busy, input logic e_done, input logic e_ovf, input logic e_err);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.load = load; v.inc = inc; v.load_val = load_val;
    v.e_value = e_value; v.e_busy = e_busy; v.e_done = e_done; v.e_ovf = e_ovf; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumes them.
  task automatic applyStimulus(input logic rst_n, input logic load, input logic inc, input logic [7:0] load_val);
    reset_       = rst_n;
    bus.load     = load;
    bus.inc      = inc;
    bus.load_val = load_val;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic [7:0] e_value, input logic e_busy,
                          input logic e_done, input logic e_ovf, input logic e_err);
    checkOutput({name, ".value"}, bus.value, e_value);
    checkOutput({name, ".busy"},  {7'd0, bus.busy}, {7'd0, e_busy});
    checkOutput({name, ".done"},  {7'd0, bus.done}, {7'd0, e_done});
    checkOutput({name, ".ovf"},   {7'd0, bus.ovf},  {7'd0, e_ovf});
    checkOutput({name, ".err"},   {7'd0, bus.err},  {7'd0, e_err});
  endtask

  initial begin
    int busy_cycles;
    int done_count;
    bit finished;

    //      name            rst ld inc load_val  value  busy done ovf err
    addVec("inc0_start",    1, 0, 1, 8'h00,    8'h00, 1, 0, 0, 0);
    addVec("inc0_end",      1, 0, 0, 8'h00,    8'h01, 0, 1, 0, 0);
    addVec("inc0_idle",     1, 0, 0, 8'h00,    8'h01, 0, 0, 0, 0);
    addVec("load_1A",       1, 1, 0, 8'h1A,    8'h1A, 0, 0, 0, 0);
    addVec("inc1A_start",   1, 0, 1, 8'h00,    8'h1A, 1, 0, 0, 0);
    addVec("inc1A_d0",      1, 0, 0, 8'h00,    8'h18, 1, 0, 0, 0);
    addVec("inc1A_d1",      1, 0, 0, 8'h00,    8'h10, 1, 0, 0, 0);
    addVec("inc1A_end",     1, 0, 0, 8'h00,    8'h20, 0, 1, 0, 0);
    addVec("load_AA",       1, 1, 0, 8'hAA,    8'hAA, 0, 0, 0, 0);
    addVec("incAA_start",   1, 0, 1, 8'h00,    8'hAA, 1, 0, 0, 0);
    addVec("incAA_d0",      1, 0, 0, 8'h00,    8'hA8, 1, 0, 0, 0);
    addVec("incAA_d1",      1, 0, 0, 8'h00,    8'hA0, 1, 0, 0, 0);
    addVec("incAA_d2",      1, 0, 0, 8'h00,    8'h80, 1, 0, 0, 0);
    addVec("incAA_end",     1, 0, 0, 8'h00,    8'h00, 0, 1, 1, 0);
    addVec("ovf_hold",      1, 0, 0, 8'h00,    8'h00, 0, 0, 1, 0);
    addVec("load_and_inc",  1, 1, 1, 8'h05,    8'h05, 0, 0, 0, 0);
    addVec("inc_dropped",   1, 0, 0, 8'h00,    8'h05, 0, 0, 0, 0);
    addVec("inc05_start",   1, 0, 1, 8'h00,    8'h05, 1, 0, 0, 0);
    addVec("inc_in_run",    1, 0, 1, 8'h00,    8'h06, 0, 1, 0, 0);
    addVec("inc05_idle",    1, 0, 0, 8'h00,    8'h06, 0, 0, 0, 0);
    addVec("load_2A",       1, 1, 0, 8'h2A,    8'h2A, 0, 0, 0, 0);
    addVec("inc2A_start",   1, 0, 1, 8'h00,    8'h2A, 1, 0, 0, 0);
    addVec("inc2A_d0",      1, 0, 0, 8'h00,    8'h28, 1, 0, 0, 0);
    addVec("reset_mid_run", 0, 0, 0, 8'h00,    8'h00, 0, 0, 0, 0);
    addVec("after_reset",   1, 0, 0, 8'h00,    8'h00, 0, 0, 0, 0);
    addVec("load_illegal",  1, 1, 0, 8'hC6,    8'h06, 0, 0, 0, 1);
    addVec("inc06_start",   1, 0, 1, 8'h00,    8'h06, 1, 0, 0, 1);
    addVec("inc06_d0",      1, 0, 0, 8'h00,    8'h04, 1, 0, 0, 1);
    addVec("inc06_end",     1, 0, 0, 8'h00,    8'h08, 0, 1, 0, 1);
    addVec("inc06_idle",    1, 0, 0, 8'h00,    8'h08, 0, 0, 0, 1);

    // Hold reset for two edges before anything else.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkAll("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].load, vecs[i].inc, vecs[i].load_val);
      checkAll(vecs[i].name, vecs[i].e_value, vecs[i].e_busy, vecs[i].e_done,
               vecs[i].e_ovf, vecs[i].e_err);
    end

    // Worst-case ripple, measured with a bounded wait: 2222 needs four busy cycles.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    busy_cycles = 0;
    done_count  = 0;
    finished    = 1'b0;
    for (int c = 0; c < 20 && !finished; c++) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_count++;
        finished = 1'b1;
      end else begin
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      end
    end
    checkOutput("worst_done_seen", {7'd0, finished}, 8'd1);
    checkOutput("worst_busy_cycles", 8'(busy_cycles), 8'd4);
    checkAll("worst_end", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("worst_done_once", {7'd0, bus.done}, 8'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h12);
    checkAll("load_clears_ovf", 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/b3_serial_incr.md
Name: b3_serial_incr

Overview:
- Digit-serial N-digit base-3 counter register. Each ternary digit is encoded in 2 bits: 00=0, 01=1, 10=2; 11 is illegal.
- Each increment command ripples a carry through the digits, LSB first, one digit per clock. A single shared base-3 half-adder cell does the arithmetic.
- Used as an event counter or sequence source in ternary arithmetic exercises.
- Provides load, increment, busy/done handshake and overflow reporting.

Parameters:
- N, 4, number of ternary digits held (N >= 2).

Ports:
- clock  in  1  system clock, rising edge.
- reset_  in  1  synchronous active-low reset. Sampled on the rising edge of clock.
- load  in  1  load request. Accepted only in IDLE.
- load_val  in  2N  value to load. Digit i is at bits [2i+1:2i].
- inc  in  1  increment request. Accepted only in IDLE.
- value  out  2N  current counter contents (registered). Same digit layout as load_val.
- busy  out  1  high while an increment is rippling.
- done  out  1  one-cycle pulse when an increment completes.
- ovf  out  1  last completed increment wrapped from all-2s to all-0s.
- err  out  1  last load contained at least one illegal 11 digit.

Behaviour:
- Reset (reset_=0 at an edge):
  - value=0, busy=0, done=0, ovf=0, err=0, state=IDLE, digit pointer=0, carry=0.
  - Reset has priority over everything, including mid-RUN. A partial ripple is discarded, with no done pulse.
- States: IDLE and RUN. Internal registers: digit pointer ptr (width clog2(N)) and carry.
- IDLE, load=1:
  - value <= load_val, except that any 11 digit is stored as 00.
  - err <= 1 if any digit was 11, else err <= 0.
  - ovf <= 0. No done pulse. Stays in IDLE.
- IDLE, load=0 and inc=1:
  - state <= RUN, busy <= 1, ptr <= 0, carry <= 1.
  - ovf <= 0, err unchanged.
- IDLE, load=1 and inc=1 together: load wins and inc is dropped.
- RUN, each edge:
  - Half-adder inputs: digit[ptr] and carry. Outputs: sum and cout.
  - digit[ptr] <= sum, carry <= cout.
  - If cout=0 or ptr=N-1: state <= IDLE, busy <= 0, done <= 1 for exactly one cycle, ovf <= (cout & ptr==N-1).
  - Otherwise: ptr <= ptr+1.
- load and inc during RUN are ignored. There is no queueing; the requester must wait for busy=0.
- Latency: for an increment whose carry stops at digit j (0..N-1), busy is high for j+1 cycles. done is high in the cycle right after busy falls. Best case is 1 busy cycle; worst case (all 2s) is N busy cycles.
- done stays low in every cycle other than the completion pulse.
- ovf and err hold their values until the next accepted command or reset.
- Half-adder truth table (digit, cin -> sum, cout):
  - 0,0 -> 0,0
  - 0,1 -> 1,0
  - 1,0 -> 1,0
  - 1,1 -> 2,0
  - 2,0 -> 2,0
  - 2,1 -> 0,1
  - Digit 11 cannot occur, because loads sanitise it.
- value changes only on the edges listed above. Digits other than digit[ptr] are never modified during RUN.

Decomposition:
- Shared package/header holds:
  - digit encodings B3_ZERO=2'b00, B3_ONE=2'b01, B3_TWO=2'b10, B3_ILL=2'b11;
  - state encodings S_IDLE, S_RUN.
- One natural sub-module: the team's existing base-3 half adder, b3_halfadder (gate-level variant acceptable), instantiated once. Its operands are muxed by ptr.
- The FSM, pointer, carry register and digit register file stay in b3_serial_incr.

Test Plan (N=4, values written as d3d2d1d0):
- Hold reset_=0 for 2 cycles, then release -> value=8'h00, busy=0, done=0, ovf=0, err=0.
- From 0000, pulse inc -> busy high 1 cycle, then value=0001 (8'h01), done pulses once, ovf=0.
- Load 0122 (8'h1A), then pulse inc -> busy high 3 cycles, value=0200 (8'h20), done pulses once, ovf=0.
- Load 2222 (8'hAA), then pulse inc -> busy high 4 cycles, value=0000, done pulses, ovf=1. A following load clears ovf.
- In IDLE, assert load=1 (load_val=8'h05) and inc=1 in the same cycle -> value=0011 (8'h05), busy stays 0. Then pulse inc, and pulse inc again while busy -> only one increment takes effect, final value=0012 (8'h06).
- Pulse inc with value=0222; drive reset_=0 in the second RUN cycle -> next edge gives value=0, busy=0 and no done pulse. Then load 8'b11_00_01_10 -> value=8'h06, err=1.
